// File: rtl/mod12_hour_display.sv
// mod12_hour_display: turns a modulo-12 count into a 12-hour BCD hour, an AM/PM flag,
// a wrap pulse, a sticky illegal-count flag and a multiplexed two-digit 7-segment drive.
module mod12_hour_display #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic       wrap_pulse,
  output logic       err,
  output logic [1:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] Q_MAX = 4'd11;

  logic [3:0]       q_r;
  logic [3:0]       q_p;
  logic [CNT_W-1:0] ref_cnt;
  logic             sel;
  logic [7:0]       hour_map_c;
  logic             wrap_c;
  logic [3:0]       digit_c;

  // Seven-segment encoding, seg[6:0] = g..a; non-decimal nibbles blank.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Count-to-hour mapping; an illegal captured count holds the previous hour.
  always_comb begin
    hour_map_c = hour_bcd;
    if (q_r == 4'd0) begin
      hour_map_c = 8'h12;
    end else if (q_r <= 4'd9) begin
      hour_map_c = {4'h0, q_r};
    end else if (q_r == 4'd10) begin
      hour_map_c = 8'h10;
    end else if (q_r == Q_MAX) begin
      hour_map_c = 8'h11;
    end
  end

  // A wrap needs a legal 11 immediately followed by a captured 0.
  assign wrap_c = (q_p == Q_MAX) && (q_r == 4'd0);

  // Input capture, hour, AM/PM, wrap and error state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r        <= 4'd0;
      q_p        <= 4'd0;
      hour_bcd   <= 8'h12;
      pm         <= 1'b0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      q_r        <= q;
      q_p        <= q_r;
      hour_bcd   <= hour_map_c;
      wrap_pulse <= wrap_c;
      if (wrap_c) begin
        pm <= ~pm;
      end
      if (q_r > Q_MAX) begin
        err <= 1'b1;
      end
    end
  end

  // Digit refresh timer: each digit is driven for REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_cnt <= '0;
      sel     <= 1'b0;
    end else if (ref_cnt == CNT_MAX) begin
      ref_cnt <= '0;
      sel     <= ~sel;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  // Display decode from registers only, with leading-zero blanking on the tens digit.
  always_comb begin
    digit_c = sel ? hour_bcd[7:4] : hour_bcd[3:0];
    an      = sel ? 2'b10 : 2'b01;
    seg     = enc(digit_c);
    if (sel && (hour_bcd[7:4] == 4'd0)) begin
      seg = 7'h00;
    end
  end

endmodule

// File: tb/tb_mod12_hour_display.sv
// Self-checking bench for mod12_hour_display against a 12-hour clock reference model.
module tb_mod12_hour_display;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q = 4'd0;
  logic [7:0] hour_bcd;
  logic       pm;
  logic       wrap_pulse;
  logic       err;
  logic [1:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  // Reference model state: captured counts, hour as an integer 1..12, flags, cycles since reset.
  int m_qr = 0;
  int m_qp = 0;
  int m_hour = 12;
  bit m_pm = 1'b0;
  bit m_wrap = 1'b0;
  bit m_err = 1'b0;
  int m_cyc = 0;

  logic [6:0] segtab [10];

  mod12_hour_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .q(q), .hour_bcd(hour_bcd), .pm(pm),
    .wrap_pulse(wrap_pulse), .err(err), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_bcd();
    return {4'(m_hour / 10), 4'(m_hour % 10)};
  endfunction

  function automatic bit exp_sel();
    return ((m_cyc / DIV) % 2) == 1;
  endfunction

  function automatic logic [1:0] exp_an();
    return exp_sel() ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [6:0] exp_seg();
    int tens, ones;
    tens = m_hour / 10;
    ones = m_hour % 10;
    if (exp_sel()) return (tens == 0) ? 7'h00 : segtab[tens];
    return segtab[ones];
  endfunction

  // One clock: drive inputs on the falling edge, advance the model at the rising edge, settle.
  task automatic tick(input logic [3:0] qv, input logic rv);
    @(negedge clk);
    q = qv;
    reset = rv;
    @(posedge clk);
    if (!rv) begin
      m_qr = 0; m_qp = 0; m_hour = 12; m_pm = 0; m_wrap = 0; m_err = 0; m_cyc = 0;
    end else begin
      m_wrap = (m_qp == 11) && (m_qr == 0);
      if (m_wrap) m_pm = !m_pm;
      if (m_qr > 11) m_err = 1;
      else m_hour = (m_qr == 0) ? 12 : m_qr;
      m_qp = m_qr;
      m_qr = int'(qv);
      m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(4'd5, 1'b0);
    checks++; if (hour_bcd !== 8'h12) begin errors++; $display("FAIL reset_hour got %h want 12", hour_bcd); end
    checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm got %b want 0", pm); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap_pulse); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (an !== 2'b01) begin errors++; $display("FAIL reset_an got %b want 01", an); end
    checks++; if (seg !== 7'h5B) begin errors++; $display("FAIL reset_seg got %h want 5b", seg); end
    tick(4'd5, 1'b1);
    checks++; if (hour_bcd !== 8'h12) begin errors++; $display("FAIL release_lat1 got %h want 12", hour_bcd); end
    tick(4'd5, 1'b1);
    checks++; if (hour_bcd !== 8'h05) begin errors++; $display("FAIL release_lat2 got %h want 05", hour_bcd); end
  endtask

  task automatic test_mapping();
    logic [3:0] vals [4];
    logic [7:0] want [4];
    vals = '{4'd3, 4'd10, 4'd11, 4'd0};
    want = '{8'h03, 8'h10, 8'h11, 8'h12};
    for (int i = 0; i < 4; i++) begin
      tick(vals[i], 1'b1);
      tick(vals[i], 1'b1);
      checks++;
      if (hour_bcd !== want[i]) begin errors++; $display("FAIL map_%0d got %h want %h", vals[i], hour_bcd, want[i]); end
    end
    for (int i = 0; i < 24; i++) begin
      tick(4'($urandom_range(0, 11)), 1'b1);
      checks++;
      if (hour_bcd !== exp_bcd()) begin errors++; $display("FAIL map_rand got %h want %h", hour_bcd, exp_bcd()); end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] seq [8];
    int pulses;
    bit pm0;
    for (int r = 0; r < 3; r++) begin
      if (r < 2) seq = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
      else       seq = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
      pulses = 0;
      pm0 = pm;
      for (int i = 0; i < 8; i++) begin
        tick(seq[i], 1'b1);
        if (wrap_pulse === 1'b1) begin
          pulses++;
          checks++;
          if (hour_bcd !== 8'h12) begin errors++; $display("FAIL wrap_align got %h want 12", hour_bcd); end
        end
        checks++;
        if (wrap_pulse !== m_wrap || pm !== m_pm) begin
          errors++; $display("FAIL wrap_cycle got w=%b pm=%b want w=%b pm=%b", wrap_pulse, pm, m_wrap, m_pm);
        end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL wrap_count got %0d want 1", pulses); end
      checks++; if (pm !== !pm0) begin errors++; $display("FAIL wrap_pm got %b want %b", pm, !pm0); end
    end
  endtask

  task automatic test_illegal();
    bit pm0;
    tick(4'd7, 1'b1); tick(4'd7, 1'b1);
    tick(4'd13, 1'b1); tick(4'd13, 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", err); end
    checks++; if (hour_bcd !== 8'h07) begin errors++; $display("FAIL illegal_hold got %h want 07", hour_bcd); end
    pm0 = pm;
    for (int i = 0; i < 3; i++) begin
      tick(4'd0, 1'b1);
      checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL illegal_nowrap got %b want 0", wrap_pulse); end
    end
    checks++; if (pm !== pm0) begin errors++; $display("FAIL illegal_pm got %b want %b", pm, pm0); end
    checks++; if (hour_bcd !== 8'h12) begin errors++; $display("FAIL illegal_recover got %h want 12", hour_bcd); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b want 1", err); end
  endtask

  task automatic test_refresh();
    int run;
    logic [1:0] prev_an;
    tick(4'd10, 1'b0);
    run = 0;
    prev_an = an;
    for (int i = 0; i < 24; i++) begin
      tick(4'd10, 1'b1);
      checks++;
      if (an !== exp_an() || seg !== exp_seg()) begin
        errors++; $display("FAIL refresh_10 got an=%b seg=%h want an=%b seg=%h", an, seg, exp_an(), exp_seg());
      end
      if (an === prev_an) run++;
      else begin
        if (i > 8) begin
          checks++;
          if (run != DIV) begin errors++; $display("FAIL refresh_len got %0d want %0d", run, DIV); end
        end
        run = 1;
      end
      prev_an = an;
    end
    for (int i = 0; i < 12; i++) begin
      tick(4'd5, 1'b1);
      checks++;
      if (an !== exp_an() || seg !== exp_seg()) begin
        errors++; $display("FAIL refresh_05 got an=%b seg=%h want an=%b seg=%h", an, seg, exp_an(), exp_seg());
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    tick(4'd11, 1'b1); tick(4'd0, 1'b1); tick(4'd13, 1'b1); tick(4'd4, 1'b1); tick(4'd4, 1'b1);
    guard = 0;
    while ((m_cyc % (2 * DIV)) != (DIV + 2) && guard < 32) begin
      tick(4'd4, 1'b1);
      guard++;
    end
    checks++;
    if (pm !== m_pm || err !== 1'b1 || an !== 2'b10) begin
      errors++; $display("FAIL midrst_pre got pm=%b err=%b an=%b want pm=%b err=1 an=10", pm, err, an, m_pm);
    end
    tick(4'd4, 1'b0);
    checks++;
    if (hour_bcd !== 8'h12 || pm !== 1'b0 || wrap_pulse !== 1'b0 || err !== 1'b0 || an !== 2'b01 || seg !== 7'h5B) begin
      errors++; $display("FAIL midrst got h=%h pm=%b w=%b e=%b an=%b seg=%h want 12 0 0 0 01 5b",
                         hour_bcd, pm, wrap_pulse, err, an, seg);
    end
  endtask

  task automatic test_random();
    logic [3:0] cur;
    logic rv;
    cur = 4'd0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 19))
        0:       cur = 4'($urandom_range(12, 15));
        1, 2:    cur = 4'($urandom_range(0, 11));
        3, 4, 5: ;
        default: cur = (cur >= 4'd11) ? 4'd0 : cur + 4'd1;
      endcase
      rv = ($urandom_range(0, 49) != 0);
      tick(cur, rv);
      checks++;
      if (hour_bcd !== exp_bcd() || pm !== m_pm || wrap_pulse !== m_wrap || err !== m_err ||
          an !== exp_an() || seg !== exp_seg()) begin
        errors++;
        $display("FAIL random_%0d got h=%h pm=%b w=%b e=%b an=%b seg=%h want h=%h pm=%b w=%b e=%b an=%b seg=%h",
                 i, hour_bcd, pm, wrap_pulse, err, an, seg,
                 exp_bcd(), m_pm, m_wrap, m_err, exp_an(), exp_seg());
      end
    end
  endtask

  initial begin
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    test_reset();
    test_mapping();
    test_wrap();
    test_illegal();
    test_refresh();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
